// File: rtl/fault_campaign_ctrl.sv
// Stuck-at fault campaign sequencer for the full-adder fault-injection datapath.
// Ports:
//   clk, rst (sync, active-high), start.
//   sum_g/cout_g and sum_f/cout_f: golden and faulty adder outputs.
//   tv_a/tv_b/tv_cin: test vector to both adders.
//   fault_enable/stuck_val: fault control to the faulty adder.
//   busy, done: campaign status.
//   golden_err, sa0_*/sa1_*: per-phase results.
// Parameter SETTLE_CYCLES (1..15).
// Optional macro FAULT_CAMPAIGN_EARLY_EXIT_EN: end P1/P2 at the first mismatch.
module fault_campaign_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sum_g,
  input  logic       cout_g,
  input  logic       sum_f,
  input  logic       cout_f,
  output logic       tv_a,
  output logic       tv_b,
  output logic       tv_cin,
  output logic       fault_enable,
  output logic       stuck_val,
  output logic       busy,
  output logic       done,
  output logic       golden_err,
  output logic       sa0_det,
  output logic       sa1_det,
  output logic [2:0] sa0_first,
  output logic [2:0] sa1_first,
  output logic [3:0] sa0_cnt,
  output logic [3:0] sa1_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DRIVE   = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;

  localparam logic [3:0] CNT_MAX = 4'd8;
  localparam bit NO_SETTLE = (SETTLE_CYCLES <= 1);
  // Last SETTLE count; only meaningful when SETTLE_CYCLES >= 2.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 2);

  logic [2:0] state_q, state_d;
  logic [2:0] v_q, v_d;
  logic [1:0] phase_q, phase_d;
  logic [3:0] scnt_q, scnt_d;
  logic [2:0] tv_q, tv_d;
  logic       fen_q, fen_d;
  logic       sval_q, sval_d;
  logic       gerr_q, gerr_d;
  logic       d0_q, d0_d;
  logic       d1_q, d1_d;
  logic [2:0] f0_q, f0_d;
  logic [2:0] f1_q, f1_d;
  logic [3:0] c0_q, c0_d;
  logic [3:0] c1_q, c1_d;

  logic mismatch;
  logic end_phase;

  assign mismatch = (sum_g != sum_f) | (cout_g != cout_f);

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    phase_d   = phase_q;
    scnt_d    = scnt_q;
    gerr_d    = gerr_q;
    d0_d      = d0_q;
    d1_d      = d1_q;
    f0_d      = f0_q;
    f1_d      = f1_q;
    c0_d      = c0_q;
    c1_d      = c1_q;
    end_phase = (v_q == 3'd7);
`ifdef FAULT_CAMPAIGN_EARLY_EXIT_EN
    if (mismatch && (phase_q != P0))
      end_phase = 1'b1;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          v_d     = 3'd0;
          phase_d = P0;
          gerr_d  = 1'b0;
          d0_d    = 1'b0;
          d1_d    = 1'b0;
          f0_d    = 3'd0;
          f1_d    = 3'd0;
          c0_d    = 4'd0;
          c1_d    = 4'd0;
        end
      end
      S_DRIVE: begin
        scnt_d  = 4'd0;
        state_d = NO_SETTLE ? S_COMPARE : S_SETTLE;
      end
      S_SETTLE: begin
        if (scnt_q == SETTLE_LAST)
          state_d = S_COMPARE;
        else
          scnt_d = scnt_q + 4'd1;
      end
      S_COMPARE: begin
        if (mismatch) begin
          if (phase_q == P0) begin
            gerr_d = 1'b1;
          end else if (phase_q == P1) begin
            if (c0_q != CNT_MAX) c0_d = c0_q + 4'd1;
            if (!d0_q) begin
              d0_d = 1'b1;
              f0_d = v_q;
            end
          end else begin
            if (c1_q != CNT_MAX) c1_d = c1_q + 4'd1;
            if (!d1_q) begin
              d1_d = 1'b1;
              f1_d = v_q;
            end
          end
        end
        if (!end_phase) begin
          v_d     = v_q + 3'd1;
          state_d = S_DRIVE;
        end else if (phase_q != P2) begin
          phase_d = phase_q + 2'd1;
          v_d     = 3'd0;
          state_d = S_DRIVE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Adder stimulus is loaded on entry to DRIVE and parked at 0 outside a sweep.
    tv_d   = tv_q;
    fen_d  = fen_q;
    sval_d = sval_q;
    if (state_d == S_DRIVE) begin
      tv_d   = v_d;
      fen_d  = (phase_d != P0);
      sval_d = (phase_d == P2);
    end else if ((state_d == S_IDLE) || (state_d == S_DONE)) begin
      tv_d   = 3'd0;
      fen_d  = 1'b0;
      sval_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      v_q     <= 3'd0;
      phase_q <= P0;
      scnt_q  <= 4'd0;
      tv_q    <= 3'd0;
      fen_q   <= 1'b0;
      sval_q  <= 1'b0;
      gerr_q  <= 1'b0;
      d0_q    <= 1'b0;
      d1_q    <= 1'b0;
      f0_q    <= 3'd0;
      f1_q    <= 3'd0;
      c0_q    <= 4'd0;
      c1_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      phase_q <= phase_d;
      scnt_q  <= scnt_d;
      tv_q    <= tv_d;
      fen_q   <= fen_d;
      sval_q  <= sval_d;
      gerr_q  <= gerr_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      f0_q    <= f0_d;
      f1_q    <= f1_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
    end
  end

  assign {tv_a, tv_b, tv_cin} = tv_q;
  assign fault_enable = fen_q;
  assign stuck_val    = sval_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign golden_err   = gerr_q;
  assign sa0_det      = d0_q;
  assign sa1_det      = d1_q;
  assign sa0_first    = f0_q;
  assign sa1_first    = f1_q;
  assign sa0_cnt      = c0_q;
  assign sa1_cnt      = c1_q;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Scoreboard testbench for fault_campaign_ctrl with behavioural adders.
// fmode: 0 = real X1 fault, 1 = fault ignored, 2 = cout_f inverted in P0.
module tb_fault_campaign_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sum_g, cout_g, sum_f, cout_f;
  logic       tv_a, tv_b, tv_cin;
  logic       fault_enable, stuck_val;
  logic       busy, done, golden_err;
  logic       sa0_det, sa1_det;
  logic [2:0] sa0_first, sa1_first;
  logic [3:0] sa0_cnt, sa1_cnt;

  int fmode = 0;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fault_campaign_ctrl #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .sum_g(sum_g), .cout_g(cout_g), .sum_f(sum_f), .cout_f(cout_f),
    .tv_a(tv_a), .tv_b(tv_b), .tv_cin(tv_cin),
    .fault_enable(fault_enable), .stuck_val(stuck_val),
    .busy(busy), .done(done), .golden_err(golden_err),
    .sa0_det(sa0_det), .sa1_det(sa1_det),
    .sa0_first(sa0_first), .sa1_first(sa1_first),
    .sa0_cnt(sa0_cnt), .sa1_cnt(sa1_cnt)
  );

  logic x1g, x1f;
  assign x1g    = tv_a ^ tv_b;
  assign sum_g  = x1g ^ tv_cin;
  assign cout_g = (tv_a & tv_b) | (tv_cin & x1g);
  assign x1f    = (fault_enable && fmode != 1) ? stuck_val : x1g;
  assign sum_f  = x1f ^ tv_cin;
  assign cout_f = ((tv_a & tv_b) | (tv_cin & x1f))
                ^ (fmode == 2 && !fault_enable);

  logic [23:0] outs;
  assign outs = {tv_a, tv_b, tv_cin, fault_enable, stuck_val, busy, done,
                 golden_err, sa0_det, sa1_det, sa0_first, sa1_first,
                 sa0_cnt, sa1_cnt};

`ifdef FAULT_CAMPAIGN_EARLY_EXIT_EN
  localparam int LAT_DET = 25;
  localparam int CNT_DET = 1;
`else
  localparam int LAT_DET = 49;
  localparam int CNT_DET = 4;
`endif

  typedef struct {
    int cyc;
    int gerr;
    int d0;
    int f0;
    int c0;
    int d1;
    int f1;
    int c1;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(int g, int d0, int f0, int c0,
                              int d1, int f1, int c1);
    exp_t e;
    e.cyc = 0; e.gerr = g;
    e.d0 = d0; e.f0 = f0; e.c0 = c0;
    e.d1 = d1; e.f1 = f1; e.c1 = c1;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cyc %0d, required none", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", cyc, mon_e.cyc);
        chk("golden_err", int'(golden_err), mon_e.gerr);
        chk("sa0_det", int'(sa0_det), mon_e.d0);
        chk("sa0_first", int'(sa0_first), mon_e.f0);
        chk("sa0_cnt", int'(sa0_cnt), mon_e.c0);
        chk("sa1_det", int'(sa1_det), mon_e.d1);
        chk("sa1_first", int'(sa1_first), mon_e.f1);
        chk("sa1_cnt", int'(sa1_cnt), mon_e.c1);
      end
    end
  end

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending done, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic campaign(input string name, input exp_t e, input int lat);
    @(negedge clk);
    start = 1'b1;
    e.cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy"}, int'(busy), 1);
    wait_empty(name);
    @(negedge clk);
    chk({name, "_idle_ctl"}, int'(outs[23:17]), 0);
  endtask

  exp_t e_norm, e_none, e_gerr, e2;

  initial begin
    int c0;
    e_norm = mk(0, 1, 2, CNT_DET, 1, 0, CNT_DET);
    e_none = mk(0, 0, 0, 0, 0, 0, 0);
    e_gerr = mk(1, 1, 2, CNT_DET, 1, 0, CNT_DET);

    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", int'(outs), 0);
    rst = 1'b0;
    @(negedge clk);

    fmode = 0;
    campaign("normal", e_norm, LAT_DET);

    fmode = 1;
    campaign("no_fault", e_none, 49);

    fmode = 2;
    campaign("gerr", e_gerr, LAT_DET);
    fmode = 0;

    // Abort at cycle 20; no done may follow.
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cycle", cyc - c0, 20);
    chk("abort_outs", int'(outs), 0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("abort_idle_busy", int'(busy), 0);
    campaign("after_abort", e_norm, LAT_DET);

    // start held high across two campaigns.
    @(negedge clk);
    start = 1'b1;
    e2 = e_norm;
    e2.cyc = cyc + LAT_DET;
    sb.push_back(e2);
    e2.cyc = cyc + 2 * LAT_DET + 1;
    sb.push_back(e2);
    repeat (2 * LAT_DET + 1) @(negedge clk);
    start = 1'b0;
    wait_empty("held");
    repeat (3) @(negedge clk);
    chk("held_idle_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
